// File: rtl/matrix_fill_pkg.sv
// matrix_fill_pkg: shared constants for the matrix_fill frame-buffer writer.
// Register map, control/status bit positions, panel geometry, FSM states and
// the host-port pixel address packing.
package matrix_fill_pkg;

    localparam int unsigned COLS  = 32;
    localparam int unsigned ROWS  = 16;
    localparam int unsigned COL_W = $clog2(COLS);
    localparam int unsigned ROW_W = $clog2(ROWS);

    localparam logic [2:0] REG_P0    = 3'd0;
    localparam logic [2:0] REG_P1    = 3'd1;
    localparam logic [2:0] REG_RG    = 3'd2;
    localparam logic [2:0] REG_B     = 3'd3;
    localparam logic [2:0] REG_CTRL  = 3'd4;
    localparam logic [2:0] REG_DADDR = 3'd5;
    localparam logic [2:0] REG_DDATA = 3'd6;

    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_CLR   = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WR_LO,
        S_WR_HI
    } state_e;

    // {half_sel, row[2:0], col[4:0], hw}
    function automatic logic [9:0] pix_addr(input logic [COL_W-1:0] x,
                                            input logic [ROW_W-1:0] y,
                                            input logic             hw);
        return {y[3], y[2:0], x, hw};
    endfunction

endpackage

// File: rtl/matrix_fill_walker.sv
// matrix_fill_walker: raster x/y counter over a rectangle. load jumps to the
// origin, step advances along the row and wraps to the next row at x1, last
// flags the final pixel.
module matrix_fill_walker
    import matrix_fill_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [COL_W-1:0] x0_i,
    input  logic [ROW_W-1:0] y0_i,
    input  logic [COL_W-1:0] x1_i,
    input  logic [ROW_W-1:0] y1_i,
    output logic [COL_W-1:0] x_o,
    output logic [ROW_W-1:0] y_o,
    output logic             last_o
);

    logic [COL_W-1:0] x_q, x_d;
    logic [ROW_W-1:0] y_q, y_d;

    // Next position: reload the origin, advance x, or wrap to the next row.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (load_i) begin
            x_d = x0_i;
            y_d = y0_i;
        end else if (step_i) begin
            if (x_q == x1_i) begin
                x_d = x0_i;
                y_d = y_q + ROW_W'(1);
            end else begin
                x_d = x_q + COL_W'(1);
            end
        end
    end

    // Position register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = (x_q == x1_i) && (y_q == y1_i);

endmodule

// File: rtl/matrix_fill.sv
// matrix_fill: CPU register file plus rectangle-fill engine driving the LED
// matrix scanner host port. Each pixel costs two halfword writes.
// Optional macro MATRIX_FILL_IRQ_EN adds the irq output (= irq_pend).
module matrix_fill
    import matrix_fill_pkg::*;
#(
    parameter logic [15:0] DEFAULT_RG = 16'h0000,
    parameter logic [7:0]  DEFAULT_B  = 8'h00
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  cpu_addr,
    input  logic [15:0] cpu_data_in,
    input  logic        cpu_write,
    output logic [15:0] cpu_data_out,
    output logic [9:0]  mem_address,
    output logic [15:0] mem_data,
    output logic        mem_write,
    input  logic [15:0] mem_data_in
`ifdef MATRIX_FILL_IRQ_EN
    ,
    output logic        irq
`endif
);

    state_e      state_q, state_d;
    logic [8:0]  p0_q, p0_d, p1_q, p1_d;
    logic [15:0] rg_q, rg_d, fill_rg_q, fill_rg_d;
    logic [7:0]  b_q, b_d, fill_b_q, fill_b_d;
    logic [9:0]  daddr_q, daddr_d;
    logic        err_q, err_d, irq_pend_q, irq_pend_d;

    logic             busy, ctrl_wr, start, empty, done;
    logic             walk_load, walk_step, walk_last;
    logic [COL_W-1:0] walk_x;
    logic [ROW_W-1:0] walk_y;

    assign busy    = (state_q != S_IDLE);
    assign ctrl_wr = cpu_write && (cpu_addr == REG_CTRL);
    assign start   = ctrl_wr && cpu_data_in[CTRL_START] && !busy;
    assign empty   = (p1_q[4:0] < p0_q[4:0]) || (p1_q[8:5] < p0_q[8:5]);

    matrix_fill_walker u_walker (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (walk_load),
        .step_i (walk_step),
        .x0_i   (p0_q[4:0]),
        .y0_i   (p0_q[8:5]),
        .x1_i   (p1_q[4:0]),
        .y1_i   (p1_q[8:5]),
        .x_o    (walk_x),
        .y_o    (walk_y),
        .last_o (walk_last)
    );

    // Fill sequencing: load origin, then lo/hi halfword per pixel until last.
    always_comb begin
        state_d   = state_q;
        walk_load = 1'b0;
        walk_step = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD: begin
                walk_load = 1'b1;
                if (empty) begin
                    state_d = S_IDLE;
                    done    = 1'b1;
                end else begin
                    state_d = S_WR_LO;
                end
            end
            S_WR_LO: state_d = S_WR_HI;
            S_WR_HI: begin
                if (walk_last) begin
                    state_d = S_IDLE;
                    done    = 1'b1;
                end else begin
                    walk_step = 1'b1;
                    state_d   = S_WR_LO;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Register file updates; while busy, writes are dropped and flag err.
    // Clear is applied first so a same-cycle error or completion still wins.
    always_comb begin
        p0_d       = p0_q;
        p1_d       = p1_q;
        rg_d       = rg_q;
        b_d        = b_q;
        daddr_d    = daddr_q;
        err_d      = err_q;
        irq_pend_d = irq_pend_q;
        fill_rg_d  = fill_rg_q;
        fill_b_d   = fill_b_q;
        if (state_q == S_LOAD) begin
            fill_rg_d = rg_q;
            fill_b_d  = b_q;
        end
        if (ctrl_wr && cpu_data_in[CTRL_CLR]) begin
            err_d      = 1'b0;
            irq_pend_d = 1'b0;
        end
        if (cpu_write) begin
            if (busy) begin
                case (cpu_addr)
                    REG_P0, REG_P1, REG_RG, REG_B, REG_DADDR, REG_DDATA: err_d = 1'b1;
                    REG_CTRL: if (cpu_data_in[CTRL_START]) err_d = 1'b1;
                    default: ;
                endcase
            end else begin
                case (cpu_addr)
                    REG_P0:    p0_d    = cpu_data_in[8:0];
                    REG_P1:    p1_d    = cpu_data_in[8:0];
                    REG_RG:    rg_d    = cpu_data_in;
                    REG_B:     b_d     = cpu_data_in[7:0];
                    REG_DADDR: daddr_d = cpu_data_in[9:0];
                    REG_DDATA: daddr_d = daddr_q + 10'd1;
                    default: ;
                endcase
            end
        end
        if (done) irq_pend_d = 1'b1;
    end

    // State and register file storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            p0_q       <= '0;
            p1_q       <= '0;
            rg_q       <= DEFAULT_RG;
            b_q        <= DEFAULT_B;
            fill_rg_q  <= DEFAULT_RG;
            fill_b_q   <= DEFAULT_B;
            daddr_q    <= '0;
            err_q      <= 1'b0;
            irq_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            p0_q       <= p0_d;
            p1_q       <= p1_d;
            rg_q       <= rg_d;
            b_q        <= b_d;
            fill_rg_q  <= fill_rg_d;
            fill_b_q   <= fill_b_d;
            daddr_q    <= daddr_d;
            err_q      <= err_d;
            irq_pend_q <= irq_pend_d;
        end
    end

    // Host port mux: fill engine owns the port in WR_LO/WR_HI, else direct path.
    always_comb begin
        mem_address = daddr_q;
        mem_data    = cpu_data_in;
        mem_write   = 1'b0;
        case (state_q)
            S_WR_LO: begin
                mem_address = pix_addr(walk_x, walk_y, 1'b0);
                mem_data    = fill_rg_q;
                mem_write   = 1'b1;
            end
            S_WR_HI: begin
                mem_address = pix_addr(walk_x, walk_y, 1'b1);
                mem_data    = {fill_b_q, 8'h00};
                mem_write   = 1'b1;
            end
            default: mem_write = cpu_write && (cpu_addr == REG_DDATA) && !busy;
        endcase
    end

    // Register readback.
    always_comb begin
        cpu_data_out = '0;
        case (cpu_addr)
            REG_P0:    cpu_data_out = {7'b0, p0_q};
            REG_P1:    cpu_data_out = {7'b0, p1_q};
            REG_RG:    cpu_data_out = rg_q;
            REG_B:     cpu_data_out = {8'h00, b_q};
            REG_CTRL:  cpu_data_out = {13'b0, irq_pend_q, err_q, busy};
            REG_DADDR: cpu_data_out = {6'b0, daddr_q};
            REG_DDATA: cpu_data_out = mem_data_in;
            default:   cpu_data_out = '0;
        endcase
    end

`ifdef MATRIX_FILL_IRQ_EN
    assign irq = irq_pend_q;
`endif

endmodule

// File: doc/matrix_fill.md
# matrix_fill

CPU-facing frame-buffer writer that sits directly upstream of the LED matrix scanner and drives its host-side memory port (10-bit halfword address, 16-bit write data, write strobe, 16-bit readback). It provides a small register file through which software either writes single halfwords with auto-increment, or launches a hardware rectangle fill of a 32x16 panel with one 24-bit colour. The fill engine generates two halfword writes per pixel, so software never computes the packed pixel layout.

## Interface
- DEFAULT_RG, 16'h0000, reset value of the colour RG register {red[7:0], green[7:0]}
- DEFAULT_B, 8'h00, reset value of the colour blue register
- clk  in  1  system clock; the only clock
- rst_n  in  1  reset, asynchronous, active-low
- cpu_addr  in  3  register select
- cpu_data_in  in  16  register write data
- cpu_write  in  1  one-cycle register write strobe
- cpu_data_out  out  16  combinational register read data for cpu_addr
- mem_address  out  10  scanner host address {half_sel, row[2:0], col[4:0], hw}
- mem_data  out  16  scanner host write data
- mem_write  out  1  scanner host write strobe
- mem_data_in  in  16  scanner host readback (1-cycle synchronous RAM latency)
- irq  out  1  fill-complete interrupt (present only with MATRIX_FILL_IRQ_EN)

## Operation
- Pixel (x,y), x 0..31, y 0..15: half_sel=y[3], row=y[2:0], col=x. hw=0 carries {red,green}; hw=1 carries {blue, 8'h00}.
- Registers: 0 P0 {7'b0, y0[3:0], x0[4:0]}; 1 P1 {y1, x1} same format; 2 colour RG; 3 colour B (bits 7:0); 4 control/status; 5 direct address[9:0]; 6 direct data.
- Ctrl write: bit0=1 starts a fill; bit1=1 clears err and irq_pend. Status read: {13'b0, irq_pend, err, busy}.
- Reg 6 write: drives one mem_write of cpu_data_in at direct address in the same cycle, then direct address increments modulo 1024. Reg 6 read returns mem_data_in.
- FSM states: IDLE, LOAD, WR_LO, WR_HI.
  - IDLE→LOAD on start. LOAD latches colour, sets x=x0, y=y0; if x1<x0 or y1<y0 → IDLE with zero writes (counts as completion).
  - LOAD→WR_LO. WR_LO writes hw0 → WR_HI. WR_HI writes hw1; if x==x1 and y==y1 → IDLE (completion); else if x==x1, x=x0, y=y+1; else x=x+1; → WR_LO.
- busy = state != IDLE. While busy: writes to regs 0-3, 5, 6 and a new start are dropped and set err (sticky); ctrl bit1 clear is still honoured.
- mem_address/mem_data come from the FSM in WR_LO/WR_HI, else from direct address/cpu_data_in.

## Timing
- Reset: state IDLE, P0=P1=0, colour=DEFAULT_RG/DEFAULT_B, direct address 0, err=0, irq_pend=0; mem_write=0, busy=0, irq=0.
- Start write at edge E0: LOAD during cycle after E0; first mem_write one cycle later. P pixels → exactly 2P consecutive mem_write cycles, no gaps; busy high for 2P+1 cycles. Empty rectangle: busy for 1 cycle.
- Completion sets irq_pend on the edge leaving WR_HI (or LOAD); clear in the same cycle as completion loses to set.
- mem_write is registered-free: asserted combinationally in WR_LO/WR_HI or on cpu_write to reg 6 while idle.
- Reset mid-fill aborts immediately; no further writes; partially drawn pixels remain in memory.

## Configuration
- MATRIX_FILL_IRQ_EN defined: irq port exists, irq = irq_pend, held until ctrl bit1 clear.
- Undefined: no irq port; irq_pend still tracked and readable in status bit2.

## Structure
- Package matrix_fill_pkg: register index constants, FSM state enum, ctrl/status bit positions, panel dimensions (32 columns, 16 rows), pixel address-packing function.
- One sub-module, matrix_fill_walker: x/y rectangle counter with load, step and last outputs; the top holds registers, FSM and muxes.

## Test plan
- Reset → status reads 0, colour regs read DEFAULT_RG/DEFAULT_B, no mem_write.
- Fill P0=(0,0) P1=(1,0), RG=16'hAB12, B=8'h34 → writes 0x000=AB12, 0x001=3400, 0x002=AB12, 0x003=3400; busy 5 cycles.
- Fill P0=(31,7) P1=(31,8) → addresses 0x0FE,0x0FF then 0x23E,0x23F (row wrap crosses half_sel).
- P1.x<P0.x → no mem_write, busy 1 cycle, irq_pend=1; ctrl write 16'h0002 → irq_pend=0.
- Reg 5=10'h3FF, two reg-6 writes 16'h1111,16'h2222 → writes at 0x3FF then 0x000.
- Write reg 2 during fill → colour unchanged, err=1, fill output unchanged.
